// File: rtl/mem_port_arbiter.sv
// Shares one pipelined memory port between fetch and load/store; data wins and a starvation counter forces fetch through.
// Latency: zero-cycle grant, read data MEM_LAT cycles after issue; backpressure: a requester holds its request until its grant is seen.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_wsel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [1:0]        m_wsel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_D      = 1'b1;

    logic [3:0] scnt;
    logic       force_if;
    logic [1:0] tag_q [MEM_LAT];
    logic [1:0] tag_in;
    logic [1:0] tag_tail;

    assign force_if = (scnt == STARVE_LIM);

    // Grants are gated by reset so nothing issues while the tag pipe is being cleared.
    assign d_gnt  = reset & d_req & ~force_if;
    assign if_gnt = reset & if_req & (~d_req | force_if);
    assign m_en   = if_gnt | d_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_wsel  = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_we    = d_we;
            m_wsel  = d_wsel;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (if_gnt) begin
            m_wsel  = 2'b10;
            m_addr  = if_addr;
        end
    end

    // Tag = {valid_read, owner}; stores and idle cycles push an invalid tag.
    assign tag_in = {if_gnt | (d_gnt & ~d_we), d_gnt ? OWN_D : OWN_IF};

    always_ff @(posedge clk) begin
        if (!reset) begin
            scnt <= 4'd0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= 2'b00;
            end
        end else begin
            if (if_gnt || !if_req) begin
                scnt <= 4'd0;
            end else if (d_gnt) begin
                scnt <= scnt + 4'd1;
            end
            tag_q[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_tail  = tag_q[MEM_LAT-1];
    assign if_rvalid = reset & tag_tail[1] & (tag_tail[0] == OWN_IF);
    assign d_rvalid  = reset & tag_tail[1] & (tag_tail[0] == OWN_D);
    assign if_rdata  = m_rdata;
    assign d_rdata   = m_rdata;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, pipelined unified memory between the pipelined RISC-V core's instruction-fetch port and its load/store (MEM-stage) port. At most one access is issued per cycle. Data accesses get priority, and a starvation counter guarantees forward progress for fetch. Read data is routed back to the requester that issued the read, after a fixed memory latency; a requester stalls whenever its grant is low.

## Interface

- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: cycles from issue to `m_rdata` valid; legal range 1..4.
- `STARVE_MAX`, default 4: maximum consecutive data grants while fetch is waiting; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request (read only).
- `if_addr`  in  ADDR_W  fetch address (PC).
- `if_gnt`  out  1  fetch request issued this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  DATA_W  fetch read data (instruction).
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_wsel`  in  2  store size: 00 byte, 01 half, 10 word (MemWriteSelect encoding).
- `d_addr`  in  ADDR_W  data address (DataAdr).
- `d_wdata`  in  DATA_W  store data (WriteData).
- `d_gnt`  out  1  data request issued this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  DATA_W  load data (ReadData).
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable.
- `m_wsel`  out  2  memory store size.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_rdata`  in  DATA_W  memory read data, valid MEM_LAT cycles after issue.

## Operation

- **Request protocol.** A requester holds `req` and all of its qualifiers stable until it sees `gnt` high. `gnt` means the access was issued this cycle. The requester may present a new request in the following cycle.
- **Arbitration.** `d_gnt = d_req & ~force_if`. `if_gnt = if_req & (~d_req | force_if)`. The two grants are never high together.
- **Starvation counter `scnt`** (4 bits):
  - increments on each `d_gnt` while `if_req` is high;
  - clears on `if_gnt`, or on any cycle with `if_req` low;
  - `force_if = (scnt == STARVE_MAX)`.
- **Memory mux.**
  - `m_en = if_gnt | d_gnt`.
  - When `d_gnt` is high, the `m_*` outputs carry the data port's fields.
  - When `if_gnt` is high, they carry `if_addr` with `m_we = 0`, `m_wsel = 10`, `m_wdata = 0`.
  - When `m_en = 0`, all `m_*` outputs are 0.
- **Return tracking.** A MEM_LAT-deep shift register of 2-bit tags records each issue: `{valid_read, owner}`. Stores push an invalid tag. At the tail of the register:
  - `if_rvalid` asserts when `valid_read & owner = IF`;
  - `d_rvalid` asserts when `valid_read & owner = D`.
- **Read data.** `if_rdata` and `d_rdata` both pass `m_rdata` directly. Each is defined only while its rvalid is high.
- **Ordering.** Returns come back in issue order and never overlap, because there is one issue per cycle.
- **Reset** (reset low at a clock edge):
  - `scnt`, the tag pipe and all registered state clear.
  - While reset is low, both grants and `m_en` are forced to 0.
  - In-flight reads are dropped: no rvalid is produced for them after reset, even if `m_rdata` later changes.

## Timing

- **Grants.** Combinational from `req`, `scnt` and reset; zero-cycle issue.
- **Read latency.** Grant in cycle N gives rvalid in cycle N+MEM_LAT, for exactly one cycle.
- **Throughput.** One access per cycle; reads and stores are fully pipelined.
- **Reset values.**
  - `if_gnt`, `d_gnt`, `m_en`, `m_we` = 0.
  - `m_wsel`, `m_addr`, `m_wdata` = 0.
  - `if_rvalid`, `d_rvalid` = 0.
  - `scnt` = 0.
- **Simultaneous requests with `scnt < STARVE_MAX`.** Data wins; fetch waits with its request held.
- **Continuous contention.** The grant pattern is STARVE_MAX data grants, then 1 fetch grant, repeating.
- **Store with both requests pending.** A store counts toward `scnt` exactly like a load.
- **Fetch withdraws (`if_req` drops) before being granted.** `scnt` clears that cycle; no fetch issue occurs.
- **Reset released.** The first grant can occur in the same cycle that reset goes high.

## Test plan

- **Reset.** Hold reset low for 3 cycles with both `if_req` and `d_req` high.
  - Required: `if_gnt = d_gnt = m_en = 0`, and no rvalid appears during reset.
- **Fetch only.** MEM_LAT=2, `if_req` with `if_addr = 0x100`, memory model returns 0x00500093.
  - Required: `if_gnt` in the same cycle; `if_rvalid = 1` with `if_rdata = 0x00500093` exactly 2 cycles later; `d_rvalid` stays 0.
- **Collision.** Load at 0x2000 and fetch at 0x104 requested in the same cycle.
  - Required: `d_gnt` in cycle N, `if_gnt` in cycle N+1.
  - Required: `d_rvalid` at N+MEM_LAT, then `if_rvalid` at N+1+MEM_LAT, each carrying its own address's data.
- **Starvation.** STARVE_MAX=4, both requests held high for 12 cycles.
  - Required grant sequence: D D D D I D D D D I D D.
- **Byte store.** `d_we = 1`, `d_wsel = 00`, `d_addr = 0x3001`, `d_wdata = 0xAB`.
  - Required: `m_en = m_we = 1`, `m_wsel = 00`, `m_addr = 0x3001`, `m_wdata = 0xAB`; no `d_rvalid` at any later cycle.
- **Reset mid-flight.** MEM_LAT=3; a load is granted in cycle N; reset is low in cycle N+1.
  - Required: no `d_rvalid` in cycles N+1..N+5.
